// File: rtl/decode_67b_64b_if.sv
// Bus bundle between the RX gearbox side and the 64B/67B decoder.
// The master drives line words; the slave (the decoder) returns decoded data and status.
interface decode_67b_64b_if;
    logic [66:0] data_in;
    logic        passthrough;
    logic [63:0] data_out;
    logic [1:0]  header_out;
    logic        data_valid;
    logic        block_lock;
    logic        header_err;
    logic        rx_slip;
    logic        disp_err;

    modport master (
        output data_in, passthrough,
        input  data_out, header_out, data_valid, block_lock, header_err, rx_slip, disp_err
    );

    modport slave (
        input  data_in, passthrough,
        output data_out, header_out, data_valid, block_lock, header_err, rx_slip, disp_err
    );
endinterface

// File: rtl/decode_67b_64b.sv
// 64B/67B receive decoder: undoes payload inversion, acquires word lock, requests gearbox slips.
// Optional running-disparity monitor is built only when DECODE_DISP_CHECK_EN is defined.
module decode_67b_64b #(
    parameter int unsigned LOCK_GOOD  = 64,
`ifdef DECODE_DISP_CHECK_EN
    parameter int unsigned DISP_LIMIT = 128,
`endif
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned UNLOCK_BAD = 16,
    parameter int unsigned SLIP_WAIT  = 32
) (
    input logic               USER_CLK,
    input logic               SYSTEM_RESET,
    decode_67b_64b_if.slave   bus
);

    localparam logic [7:0] LockGoodC  = 8'(LOCK_GOOD);
    localparam logic [7:0] WinLastC   = 8'(WINDOW - 1);
    localparam logic [7:0] UnlockBadC = 8'(UNLOCK_BAD);
    localparam logic [7:0] SlipWaitC  = 8'(SLIP_WAIT);

    typedef enum logic [1:0] {StSearch, StSlipWait, StLocked} state_e;

    state_e      state_q, state_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  bad_cnt_q, bad_cnt_d;
    logic        slip_d;

    logic [63:0] data_out_q;
    logic [1:0]  header_out_q;
    logic        data_valid_q;
    logic        block_lock_q;
    logic        header_err_q;
    logic        rx_slip_q;

    logic [1:0]  hdr;
    logic        hdr_good;
    logic [63:0] payload;
    logic [7:0]  good_inc, wait_inc, hdr_inc, bad_inc;

    assign hdr      = bus.data_in[65:64];
    assign hdr_good = hdr[1] ^ hdr[0];
    assign payload  = bus.data_in[63:0];
    assign good_inc = good_cnt_q + 8'd1;
    assign wait_inc = wait_cnt_q + 8'd1;
    assign hdr_inc  = hdr_cnt_q + 8'd1;
    assign bad_inc  = bad_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        wait_cnt_d = wait_cnt_q;
        hdr_cnt_d  = hdr_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        slip_d     = 1'b0;
        if (bus.passthrough) begin
            state_d    = StSearch;
            good_cnt_d = 8'd0;
            wait_cnt_d = 8'd0;
            hdr_cnt_d  = 8'd0;
            bad_cnt_d  = 8'd0;
        end else begin
            case (state_q)
                StSearch: begin
                    if (hdr_good) begin
                        if (good_inc == LockGoodC) begin
                            state_d    = StLocked;
                            good_cnt_d = 8'd0;
                            hdr_cnt_d  = 8'd0;
                            bad_cnt_d  = 8'd0;
                        end else begin
                            good_cnt_d = good_inc;
                        end
                    end else begin
                        slip_d     = 1'b1;
                        good_cnt_d = 8'd0;
                        wait_cnt_d = 8'd0;
                        state_d    = StSlipWait;
                    end
                end
                StSlipWait: begin
                    if (wait_inc == SlipWaitC) begin
                        state_d    = StSearch;
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_inc;
                    end
                end
                StLocked: begin
                    // Unlock check takes precedence over the window wrap.
                    if (!hdr_good && (bad_inc == UnlockBadC)) begin
                        state_d    = StSearch;
                        good_cnt_d = 8'd0;
                        wait_cnt_d = 8'd0;
                        hdr_cnt_d  = 8'd0;
                        bad_cnt_d  = 8'd0;
                    end else if (hdr_cnt_q == WinLastC) begin
                        hdr_cnt_d = 8'd0;
                        bad_cnt_d = 8'd0;
                    end else begin
                        hdr_cnt_d = hdr_inc;
                        bad_cnt_d = hdr_good ? bad_cnt_q : bad_inc;
                    end
                end
                default: begin
                    state_d = StSearch;
                end
            endcase
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state_q      <= StSearch;
            good_cnt_q   <= 8'd0;
            wait_cnt_q   <= 8'd0;
            hdr_cnt_q    <= 8'd0;
            bad_cnt_q    <= 8'd0;
            data_out_q   <= 64'd0;
            header_out_q <= 2'b00;
            data_valid_q <= 1'b0;
            block_lock_q <= 1'b0;
            header_err_q <= 1'b0;
            rx_slip_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            hdr_cnt_q    <= hdr_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            data_out_q   <= (bus.data_in[66] && !bus.passthrough) ? ~payload : payload;
            header_out_q <= hdr;
            data_valid_q <= bus.passthrough || ((state_q == StLocked) && hdr_good);
            block_lock_q <= (state_d == StLocked);
            header_err_q <= !hdr_good;
            rx_slip_q    <= slip_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.header_out = header_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.block_lock = block_lock_q;
    assign bus.header_err = header_err_q;
    assign bus.rx_slip    = rx_slip_q;

`ifdef DECODE_DISP_CHECK_EN
    logic [6:0]  ones;
    logic [8:0]  wd;
    logic [16:0] rd_sum;
    logic [15:0] rd_q, rd_d, rd_sat, rd_mag;
    logic        disp_err_q;

    always_comb begin
        ones = 7'd0;
        for (int i = 0; i < 67; i++) begin
            ones = ones + {6'd0, bus.data_in[i]};
        end
    end

    // Two's-complement word disparity, range -67..+67.
    assign wd     = {1'b0, ones, 1'b0} - 9'd67;
    assign rd_sum = {rd_q[15], rd_q} + {{8{wd[8]}}, wd};

    always_comb begin
        if (rd_sum[16] != rd_sum[15]) begin
            rd_sat = rd_sum[16] ? 16'h8000 : 16'h7fff;
        end else begin
            rd_sat = rd_sum[15:0];
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (bus.passthrough || ((state_q != StLocked) && (state_d == StLocked))) begin
            rd_d = 16'd0;
        end else if (state_q == StLocked) begin
            rd_d = rd_sat;
        end
    end

    assign rd_mag = rd_d[15] ? (~rd_d + 16'd1) : rd_d;

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            rd_q       <= 16'd0;
            disp_err_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            disp_err_q <= (rd_mag > 16'(DISP_LIMIT));
        end
    end

    assign bus.disp_err = disp_err_q;
`else
    assign bus.disp_err = 1'b0;
`endif

endmodule

// File: tb/tb_decode_67b_64b.sv
// Scoreboard bench for decode_67b_64b: a behavioural model predicts every output cycle,
// a separate monitor pops and compares after each rising edge.
module tb_decode_67b_64b;

    localparam int LockGood  = 64;
    localparam int Window    = 64;
    localparam int UnlockBad = 16;
    localparam int SlipWait  = 32;
    localparam int DispLimit = 128;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        valid;
        logic        lock;
        logic        herr;
        logic        slip;
        logic        disp;
    } exp_t;

    logic USER_CLK;
    logic SYSTEM_RESET;
    decode_67b_64b_if bus ();

    decode_67b_64b dut (
        .USER_CLK     (USER_CLK),
        .SYSTEM_RESET (SYSTEM_RESET),
        .bus          (bus)
    );

    initial begin
        USER_CLK = 1'b0;
        forever #5 USER_CLK = ~USER_CLK;
    end

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: lock flag, remaining settle cycles, good run length, window position/bads.
    bit m_locked;
    int m_settle;
    int m_run;
    int m_wpos;
    int m_wbad;
    int m_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic model_step(input bit rst, input bit pt, input logic [66:0] din,
                              output exp_t e);
        bit good;
        int wd;
        e = '0;
        if (rst) begin
            m_locked = 0; m_settle = 0; m_run = 0; m_wpos = 0; m_wbad = 0; m_rd = 0;
            return;
        end
        good   = (din[65] != din[64]);
        e.data = (!pt && din[66]) ? ~din[63:0] : din[63:0];
        e.hdr  = din[65:64];
        e.herr = !good;
        if (pt) begin
            e.valid  = 1'b1;
            m_locked = 0; m_settle = 0; m_run = 0; m_wpos = 0; m_wbad = 0; m_rd = 0;
        end else begin
            e.valid = m_locked && good;
            if (m_locked) begin
                wd   = 2 * $countones(din) - 67;
                m_rd = m_rd + wd;
                if (m_rd > 32767) m_rd = 32767;
                if (m_rd < -32768) m_rd = -32768;
                if (!good) m_wbad++;
                if (m_wbad == UnlockBad) begin
                    m_locked = 0; m_run = 0; m_wpos = 0; m_wbad = 0;
                end else if (m_wpos == Window - 1) begin
                    m_wpos = 0; m_wbad = 0;
                end else begin
                    m_wpos++;
                end
            end else if (m_settle > 0) begin
                m_settle--;
            end else if (good) begin
                m_run++;
                if (m_run == LockGood) begin
                    m_locked = 1; m_run = 0; m_wpos = 0; m_wbad = 0; m_rd = 0;
                end
            end else begin
                e.slip   = 1'b1;
                m_run    = 0;
                m_settle = SlipWait;
            end
        end
        e.lock = m_locked;
`ifdef DECODE_DISP_CHECK_EN
        e.disp = (m_rd > DispLimit) || (m_rd < -DispLimit);
`else
        e.disp = 1'b0;
`endif
    endtask

    task automatic drive(input bit rst, input bit pt, input logic [66:0] din);
        exp_t e;
        @(negedge USER_CLK);
        SYSTEM_RESET    = rst;
        bus.passthrough = pt;
        bus.data_in     = din;
        model_step(rst, pt, din, e);
        sb.push_back(e);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] any_hdr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 2'b00;
        if (r == 1) return 2'b11;
        return good_hdr();
    endfunction

    // Monitor: compare every registered output against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge USER_CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_out",   64'(bus.data_out),   64'(e.data));
                chk("header_out", 64'(bus.header_out), 64'(e.hdr));
                chk("data_valid", 64'(bus.data_valid), 64'(e.valid));
                chk("block_lock", 64'(bus.block_lock), 64'(e.lock));
                chk("header_err", 64'(bus.header_err), 64'(e.herr));
                chk("rx_slip",    64'(bus.rx_slip),    64'(e.slip));
                chk("disp_err",   64'(bus.disp_err),   64'(e.disp));
            end
        end
    end

    initial begin
        SYSTEM_RESET    = 1'b1;
        bus.passthrough = 1'b0;
        bus.data_in     = '0;

        for (int i = 0; i < 5; i++) drive(1, 0, {1'b0, 2'b01, rnd64()});

        // Acquire lock with 64 good headers, then run locked with random inversion.
        for (int i = 0; i < 64; i++) drive(0, 0, {1'b0, 2'b01, rnd64()});
        for (int i = 0; i < 10; i++) drive(0, 0, {1'($urandom), good_hdr(), rnd64()});
        drive(0, 0, {1'b1, 2'b10, 64'h0123_4567_89AB_CDEF});

        // Align to a window start, then 15 bad per window twice (lock held).
        while (m_wpos != 0) drive(0, 0, {1'b0, 2'b01, rnd64()});
        for (int w = 0; w < 2; w++) begin
            for (int p = 0; p < Window; p++) begin
                drive(0, 0, {1'($urandom), (p < 15) ? 2'b11 : good_hdr(), rnd64()});
            end
        end
        // 16th bad header lands on the last window position: lock drops, no slip.
        for (int p = 0; p < Window; p++) begin
            drive(0, 0, {1'b0, (p < 15 || p == Window - 1) ? 2'b00 : 2'b10, rnd64()});
        end

        // Unlocked bad headers: slip, settle window, second slip.
        for (int i = 0; i < 40; i++) drive(0, 0, {1'b0, 2'b11, rnd64()});
        for (int i = 0; i < 40; i++) drive(0, 0, {1'($urandom), any_hdr(), rnd64()});

        // Relock (allow settle to finish first), then passthrough while locked.
        for (int i = 0; i < 120; i++) drive(0, 0, {1'b0, 2'b01, rnd64()});
        for (int i = 0; i < 3; i++) drive(0, 1, {1'b1, 2'b00, {16{4'hA}}});
        for (int i = 0; i < 70; i++) drive(0, 0, {1'b0, 2'b10, rnd64()});

        // Disparity: all-ones payload, then long run to reach saturation, then negative swing.
        for (int i = 0; i < 3; i++) drive(0, 0, {1'b0, 2'b01, {64{1'b1}}});
        for (int i = 0; i < 600; i++) drive(0, 0, {1'b1, 2'b01, {64{1'b1}}});
        for (int i = 0; i < 20; i++) drive(0, 0, {1'b0, 2'b10, 64'd0});

        // Random traffic with occasional passthrough and mid-operation reset.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                  {1'($urandom), ($urandom_range(0, 19) == 0) ? any_hdr() : good_hdr(),
                   rnd64()});
        end

        drive(1, 0, '0);
        drive(0, 0, {1'b0, 2'b01, rnd64()});
        repeat (3) @(posedge USER_CLK);
        #2;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
